regfile_mp: RTL and testbench
=============================

REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: register width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 5: register address width; DEPTH = 2**ADDR_WIDTH.
REQ-003 SHALL have parameter NREAD, default 2, range 1..4: number of read ports.
REQ-004 SHALL have port clk, input, 1: the single clock, rising edge.
REQ-005 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-006 SHALL have ports we0/we1, input, 1 each: write enables; port 1 has priority.
REQ-007 SHALL have ports waddr0/waddr1, input, ADDR_WIDTH each, and wdata0/wdata1, input, DATA_WIDTH each: write address and data.
REQ-008 SHALL have port raddr, input, NREAD*ADDR_WIDTH: packed read addresses; port k is slice k.
REQ-009 SHALL have port rdata, output, NREAD*DATA_WIDTH: packed read data.
REQ-010 SHALL have port rpend, output, NREAD: per-read-port pending flag (value not yet produced).
REQ-011 SHALL have ports rsv_valid, input, 1, and rsv_addr, input, ADDR_WIDTH: reserve a destination register (issue).
REQ-012 SHALL have port clr, input, 1: single-cycle request for a sequential clear.
REQ-013 SHALL have port busy, output, 1: clear in progress.
REQ-014 SHALL have ports tap_addr, input, ADDR_WIDTH, and tap_data, output, DATA_WIDTH: debug observation port.

Function
REQ-015 SHALL make reads combinational: rdata slice k = entry[raddr slice k]; tap_data = entry[tap_addr].
REQ-016 SHALL make address 0 always read 0, never pending, and ignore writes and reservations to it.
REQ-017 SHALL write on the rising clk edge when weN=1, waddrN!=0 and busy=0; same-address double write: wdata1 is stored.
REQ-018 SHALL set pending[a] on the edge where rsv_valid=1 and rsv_addr=a!=0; a write to a clears pending[a].
REQ-019 SHALL let a reservation win over a write when both target the same address in the same cycle (pending stays 1, data is written).
REQ-020 SHALL drive rpend[k] = pending[raddr slice k].
REQ-021 SHALL implement FSM IDLE/CLEAR: IDLE with clr=1 -> CLEAR, counter=1, all pending bits cleared on that edge.
REQ-022 SHALL, in CLEAR, zero entry[counter] each cycle and increment the counter; after writing DEPTH-1 the FSM -> IDLE.
REQ-023 SHALL assert busy exactly in CLEAR (DEPTH-1 cycles), ignoring we0/we1 and rsv_valid; clr in CLEAR is ignored.
REQ-024 SHALL let the counter wrap naturally at ADDR_WIDTH bits with no out-of-range access.

Reset
REQ-025 SHALL, on rst assertion, asynchronously zero all entries, all pending bits and the counter, and force IDLE.
REQ-026 SHALL, during and after reset, output rdata=0, tap_data=0, rpend=0 and busy=0.
REQ-027 SHALL make rst during CLEAR abort the clear immediately; the first edge after release is treated as IDLE.

Configuration
REQ-028 SHALL honour macro REGFILE_MP_BYPASS_EN: when defined, a read or tap of an address being validly written this cycle returns the incoming wdata (wdata1 over wdata0) and rpend=0 for it.
REQ-029 SHALL, without REGFILE_MP_BYPASS_EN, return the stored (old) value and the current pending bit.

Structure
REQ-030 SHALL place the FSM state encoding (IDLE, CLEAR), the default widths and the REG_ZERO constant in package regfile_mp_pkg.
REQ-031 SHALL implement the pending-bit scoreboard as sub-module regfile_mp_sb (reserve, clear-on-write, clear-all, per-port lookup).

Verification
REQ-032 SHALL cover: we0=1 waddr0=3 wdata0=0x1234 -> next cycle raddr[0]=3 gives 0x1234; waddr0=0 write -> raddr 0 reads 0.
REQ-033 SHALL cover: we0, we1 both to addr 5 with 0xAAAA/0x5555 -> entry 5 = 0x5555.
REQ-034 SHALL cover: rsv addr 7 -> rpend=1 on reading 7; write 7 -> rpend=0; reserve and write 7 in the same cycle -> rpend stays 1.
REQ-035 SHALL cover: fill all entries with 0xFFFF_FFFF, pulse clr -> busy high for 31 cycles, writes ignored, then all entries read 0.
REQ-036 SHALL cover: rst asserted mid-CLEAR (counter=10) -> busy=0 and all outputs 0 immediately, without a clock edge.
REQ-037 SHALL cover: same-cycle write 9=0xBEEF and read 9 -> 0xBEEF with REGFILE_MP_BYPASS_EN defined, old value without it.

Source files
------------

// File: rtl/regfile_mp_pkg.sv
// Shared definitions for the multi-port register file.
//   - Default widths and read-port count.
//   - REG_ZERO: index of the hardwired-zero register.
//   - state_e: clear sequencer states.
//   - depth_of(): number of entries for a given address width.
package regfile_mp_pkg;

  localparam int unsigned DataWidthDef = 32;
  localparam int unsigned AddrWidthDef = 5;
  localparam int unsigned NReadDef     = 2;

  // Register index that always reads zero and cannot be written or reserved.
  localparam int unsigned REG_ZERO = 0;

  typedef enum logic [0:0] {
    StIdle  = 1'b0,
    StClear = 1'b1
  } state_e;

  function automatic int unsigned depth_of(input int unsigned addr_width);
    return 32'd1 << addr_width;
  endfunction

endpackage

// File: rtl/regfile_mp_sb.sv
// Pending-bit scoreboard for regfile_mp.
// One bit per register: set by a reservation, cleared by a write to that
// register, cleared wholesale when a sequential clear starts. Bit REG_ZERO is
// held at 0. A reservation wins over a write to the same register.
// Ports:
//   clk, rst       : clock, asynchronous active-high reset
//   clr_all_i      : clear every pending bit on this edge (overrides all else)
//   rsv_en_i/addr  : reservation (caller has already qualified it)
//   wclr0/1_en_i   : qualified write on port 0/1, with its address
//   raddr_i        : packed per-port lookup addresses
//   rpend_o        : pending bit for each lookup address
module regfile_mp_sb
  import regfile_mp_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = AddrWidthDef,
  parameter int unsigned NREAD      = NReadDef
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clr_all_i,
  input  logic                        rsv_en_i,
  input  logic [ADDR_WIDTH-1:0]       rsv_addr_i,
  input  logic                        wclr0_en_i,
  input  logic [ADDR_WIDTH-1:0]       wclr0_addr_i,
  input  logic                        wclr1_en_i,
  input  logic [ADDR_WIDTH-1:0]       wclr1_addr_i,
  input  logic [NREAD*ADDR_WIDTH-1:0] raddr_i,
  output logic [NREAD-1:0]            rpend_o
);

  localparam int unsigned DEPTH = depth_of(ADDR_WIDTH);

  logic [DEPTH-1:0] pend_q, pend_d;

  always_comb begin
    pend_d = pend_q;
    if (clr_all_i) begin
      pend_d = '0;
    end else begin
      if (wclr0_en_i) pend_d[wclr0_addr_i] = 1'b0;
      if (wclr1_en_i) pend_d[wclr1_addr_i] = 1'b0;
      // Applied last so a same-cycle reservation survives the write.
      if (rsv_en_i)   pend_d[rsv_addr_i]   = 1'b1;
    end
    pend_d[REG_ZERO] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

  for (genvar k = 0; k < NREAD; k++) begin : g_lookup
    assign rpend_o[k] = pend_q[raddr_i[k*ADDR_WIDTH +: ADDR_WIDTH]];
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with two write ports, NREAD combinational read
// ports, a debug tap, a pending-bit scoreboard and a sequential clear.
// Register 0 reads zero and ignores writes/reservations. Write port 1 has
// priority over port 0. A clr pulse in idle starts a walk that zeroes
// registers 1..DEPTH-1, one per cycle; busy is high during the walk and
// writes/reservations are ignored.
// Optional feature macro: REGFILE_MP_BYPASS_EN
//   defined   : reads/tap of a register being validly written this cycle
//               return the incoming data (wdata1 over wdata0), rpend=0
//   undefined : reads return the stored value and the stored pending bit
// Ports:
//   clk, rst             : clock, asynchronous active-high reset
//   we0/we1, waddr*, wdata* : write ports (1 wins on same address)
//   raddr/rdata/rpend    : packed read ports, slice k is port k
//   rsv_valid/rsv_addr   : destination reservation
//   clr/busy             : clear request / clear in progress
//   tap_addr/tap_data    : debug observation
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DataWidthDef,
  parameter int unsigned ADDR_WIDTH = AddrWidthDef,
  parameter int unsigned NREAD      = NReadDef
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        we0,
  input  logic                        we1,
  input  logic [ADDR_WIDTH-1:0]       waddr0,
  input  logic [ADDR_WIDTH-1:0]       waddr1,
  input  logic [DATA_WIDTH-1:0]       wdata0,
  input  logic [DATA_WIDTH-1:0]       wdata1,
  input  logic [NREAD*ADDR_WIDTH-1:0] raddr,
  output logic [NREAD*DATA_WIDTH-1:0] rdata,
  output logic [NREAD-1:0]            rpend,
  input  logic                        rsv_valid,
  input  logic [ADDR_WIDTH-1:0]       rsv_addr,
  input  logic                        clr,
  output logic                        busy,
  input  logic [ADDR_WIDTH-1:0]       tap_addr,
  output logic [DATA_WIDTH-1:0]       tap_data
);

  localparam int unsigned DEPTH = depth_of(ADDR_WIDTH);
  localparam int unsigned NLOOK = NREAD + 1;  // read ports plus the tap
  localparam logic [ADDR_WIDTH-1:0] ZeroAddr = ADDR_WIDTH'(REG_ZERO);
  localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] OneAddr  = ADDR_WIDTH'(1);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  busy_s;
  logic                  clr_all;
  logic                  wr0_ok, wr1_ok, rsv_ok;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];

  logic [NREAD-1:0]      sb_rpend;

  assign busy_s = (state_q == StClear);
  assign busy   = busy_s;

  assign wr0_ok = we0 && (waddr0 != ZeroAddr) && !busy_s;
  assign wr1_ok = we1 && (waddr1 != ZeroAddr) && !busy_s;
  assign rsv_ok = rsv_valid && (rsv_addr != ZeroAddr) && !busy_s;

  // Clear sequencer
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clr_all = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (clr) begin
          state_d = StClear;
          cnt_d   = OneAddr;
          clr_all = 1'b1;
        end
      end
      StClear: begin
        // Counter wraps to 0 after the last entry; it is only used in StClear.
        cnt_d = cnt_q + OneAddr;
        if (cnt_q == LastAddr) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Storage
  always_comb begin
    mem_d = mem_q;
    if (busy_s) begin
      mem_d[cnt_q] = '0;
    end else begin
      if (wr0_ok) mem_d[waddr0] = wdata0;
      if (wr1_ok) mem_d[waddr1] = wdata1;
    end
    mem_d[REG_ZERO] = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  regfile_mp_sb #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NREAD      (NREAD)
  ) u_sb (
    .clk          (clk),
    .rst          (rst),
    .clr_all_i    (clr_all),
    .rsv_en_i     (rsv_ok),
    .rsv_addr_i   (rsv_addr),
    .wclr0_en_i   (wr0_ok),
    .wclr0_addr_i (waddr0),
    .wclr1_en_i   (wr1_ok),
    .wclr1_addr_i (waddr1),
    .raddr_i      (raddr),
    .rpend_o      (sb_rpend)
  );

  // Lookups: indices 0..NREAD-1 are read ports, index NREAD is the tap.
  logic [ADDR_WIDTH-1:0] lk_addr [NLOOK];
  logic [DATA_WIDTH-1:0] lk_data [NLOOK];

  for (genvar g = 0; g < NLOOK; g++) begin : g_look
    logic [DATA_WIDTH-1:0] stored;

    if (g < NREAD) begin : g_port
      assign lk_addr[g] = raddr[g*ADDR_WIDTH +: ADDR_WIDTH];
      assign rdata[g*DATA_WIDTH +: DATA_WIDTH] = lk_data[g];
    end else begin : g_tap
      assign lk_addr[g] = tap_addr;
      assign tap_data   = lk_data[g];
    end

    assign stored = (lk_addr[g] == ZeroAddr) ? '0 : mem_q[lk_addr[g]];

`ifdef REGFILE_MP_BYPASS_EN
    logic hit0, hit1;
    // Gated by rst so forwarded data never leaks out while in reset.
    assign hit0 = !rst && wr0_ok && (waddr0 == lk_addr[g]);
    assign hit1 = !rst && wr1_ok && (waddr1 == lk_addr[g]);
    assign lk_data[g] = hit1 ? wdata1 : (hit0 ? wdata0 : stored);
    if (g < NREAD) begin : g_pend
      assign rpend[g] = sb_rpend[g] & ~(hit0 | hit1);
    end
`else
    assign lk_data[g] = stored;
`endif
  end

`ifndef REGFILE_MP_BYPASS_EN
  assign rpend = sb_rpend;
`endif

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed scenarios followed by random
// traffic, all compared against an array-based reference model.
module tb_regfile_mp;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int NR    = 2;
  localparam int DEPTH = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             we0, we1, rsv_valid, clr;
  logic [AW-1:0]    waddr0, waddr1, rsv_addr, tap_addr;
  logic [DW-1:0]    wdata0, wdata1, tap_data;
  logic [NR*AW-1:0] raddr;
  logic [NR*DW-1:0] rdata;
  logic [NR-1:0]    rpend;
  logic             busy;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [DW-1:0] m_mem  [DEPTH];
  bit            m_pend [DEPTH];
  bit            m_busy;
  int            m_next;  // next register the clear walk will zero

  regfile_mp #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .NREAD      (NR)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .we0       (we0),
    .we1       (we1),
    .waddr0    (waddr0),
    .waddr1    (waddr1),
    .wdata0    (wdata0),
    .wdata1    (wdata1),
    .raddr     (raddr),
    .rdata     (rdata),
    .rpend     (rpend),
    .rsv_valid (rsv_valid),
    .rsv_addr  (rsv_addr),
    .clr       (clr),
    .busy      (busy),
    .tap_addr  (tap_addr),
    .tap_data  (tap_data)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] exp_data(input int a);
    if (rst || a == 0) return '0;
`ifdef REGFILE_MP_BYPASS_EN
    if (!m_busy && we1 && int'(waddr1) == a) return wdata1;
    if (!m_busy && we0 && int'(waddr0) == a) return wdata0;
`endif
    return m_mem[a];
  endfunction

  function automatic bit exp_pend(input int a);
    if (rst || a == 0) return 1'b0;
`ifdef REGFILE_MP_BYPASS_EN
    if (!m_busy && ((we0 && int'(waddr0) == a) || (we1 && int'(waddr1) == a))) return 1'b0;
`endif
    return m_pend[a];
  endfunction

  task automatic model_reset();
    foreach (m_mem[i]) m_mem[i] = '0;
    foreach (m_pend[i]) m_pend[i] = 1'b0;
    m_busy = 1'b0;
    m_next = 0;
  endtask

  task automatic model_edge();
    if (rst) begin
      model_reset();
      return;
    end
    if (m_busy) begin
      m_mem[m_next] = '0;
      m_next++;
      if (m_next == DEPTH) begin
        m_busy = 1'b0;
        m_next = 0;
      end
      return;
    end
    if (we0 && waddr0 != 0) begin m_mem[waddr0] = wdata0; m_pend[waddr0] = 1'b0; end
    if (we1 && waddr1 != 0) begin m_mem[waddr1] = wdata1; m_pend[waddr1] = 1'b0; end
    if (rsv_valid && rsv_addr != 0) m_pend[rsv_addr] = 1'b1;
    if (clr) begin
      m_busy = 1'b1;
      m_next = 1;
      foreach (m_pend[i]) m_pend[i] = 1'b0;
    end
  endtask

  task automatic check_outputs();
    for (int k = 0; k < NR; k++) begin
      int a;
      a = int'(raddr[k*AW +: AW]);
      check_eq($sformatf("rdata%0d@%0d", k, a), 64'(rdata[k*DW +: DW]), 64'(exp_data(a)));
      check_eq($sformatf("rpend%0d@%0d", k, a), 64'(rpend[k]), 64'(exp_pend(a)));
    end
    check_eq($sformatf("tap@%0d", tap_addr), 64'(tap_data), 64'(exp_data(int'(tap_addr))));
    check_eq("busy", 64'(busy), 64'(!rst && m_busy));
  endtask

  // Inputs are driven at posedge+1; outputs checked at negedge.
  task automatic cycle();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_in();
    we0 = 0; we1 = 0; rsv_valid = 0; clr = 0;
    waddr0 = '0; waddr1 = '0; wdata0 = '0; wdata1 = '0;
    rsv_addr = '0; raddr = '0; tap_addr = '0;
  endtask

  task automatic set_raddr(input int k, input int a);
    raddr[k*AW +: AW] = AW'(a);
  endtask

  function automatic logic [AW-1:0] rand_addr();
    // Bias toward a few registers so collisions are frequent.
    if ($urandom_range(0, 3) == 0) return AW'($urandom_range(0, DEPTH - 1));
    return AW'($urandom_range(0, 7));
  endfunction

  task automatic rand_in();
    we0 = 1'($urandom_range(0, 1));
    we1 = 1'($urandom_range(0, 1));
    waddr0 = rand_addr();
    waddr1 = rand_addr();
    wdata0 = $urandom;
    wdata1 = $urandom;
    rsv_valid = 1'($urandom_range(0, 1));
    rsv_addr = rand_addr();
    set_raddr(0, int'(rand_addr()));
    set_raddr(1, int'(rand_addr()));
    tap_addr = rand_addr();
  endtask

  initial begin
    int n;
    model_reset();
    idle_in();

    // Reset holds everything at zero even with a write presented.
    rst = 1; we0 = 1; waddr0 = 3; wdata0 = 32'hDEAD;
    set_raddr(0, 3); set_raddr(1, 3); tap_addr = 3;
    #1;
    check_eq("rst_rdata", 64'(rdata), 64'(0));
    check_eq("rst_tap", 64'(tap_data), 64'(0));
    check_eq("rst_rpend", 64'(rpend), 64'(0));
    check_eq("rst_busy", 64'(busy), 64'(0));
    cycle();
    cycle();
    rst = 0;
    idle_in();

    // Basic write then read; write to register 0 is dropped.
    we0 = 1; waddr0 = 3; wdata0 = 32'h1234; cycle();
    idle_in(); set_raddr(0, 3); #1;
    check_eq("wr3_read", 64'(rdata[DW-1:0]), 64'h1234);
    cycle();
    we0 = 1; waddr0 = 0; wdata0 = 32'hFFFF; cycle();
    idle_in(); set_raddr(0, 0); tap_addr = 0; #1;
    check_eq("zero_read", 64'(rdata[DW-1:0]), 64'(0));
    cycle();

    // Same-address double write: port 1 wins.
    we0 = 1; waddr0 = 5; wdata0 = 32'hAAAA;
    we1 = 1; waddr1 = 5; wdata1 = 32'h5555; cycle();
    idle_in(); set_raddr(1, 5); #1;
    check_eq("dual_wr", 64'(rdata[2*DW-1:DW]), 64'h5555);
    cycle();

    // Reservation / write interplay on register 7.
    rsv_valid = 1; rsv_addr = 7; cycle();
    idle_in(); set_raddr(0, 7); #1;
    check_eq("rsv7_pend", 64'(rpend[0]), 64'(1));
    we0 = 1; waddr0 = 7; wdata0 = 32'h77; cycle();
    idle_in(); set_raddr(0, 7); #1;
    check_eq("wr7_unpend", 64'(rpend[0]), 64'(0));
    rsv_valid = 1; rsv_addr = 7; we1 = 1; waddr1 = 7; wdata1 = 32'h99; cycle();
    idle_in(); set_raddr(0, 7); #1;
    check_eq("rsvwr7_pend", 64'(rpend[0]), 64'(1));
    check_eq("rsvwr7_data", 64'(rdata[DW-1:0]), 64'h99);
    cycle();

    // Same-cycle write and read of register 9.
    we0 = 1; waddr0 = 9; wdata0 = 32'h1111; cycle();
    idle_in(); we0 = 1; waddr0 = 9; wdata0 = 32'hBEEF; set_raddr(0, 9); tap_addr = 9; #1;
`ifdef REGFILE_MP_BYPASS_EN
    check_eq("byp_read", 64'(rdata[DW-1:0]), 64'hBEEF);
`else
    check_eq("byp_read", 64'(rdata[DW-1:0]), 64'h1111);
`endif
    cycle();

    // Fill every register, then clear sequentially while hammering writes.
    for (int a = 1; a < DEPTH; a++) begin
      idle_in(); we0 = 1; waddr0 = AW'(a); wdata0 = 32'hFFFF_FFFF;
      rsv_valid = 1; rsv_addr = AW'(a); set_raddr(0, a); cycle();
    end
    idle_in(); clr = 1; cycle();
    n = 0;
    while (busy && n < 100) begin
      rand_in(); we0 = 1; clr = 1;
      n++;
      cycle();
    end
    check_eq("busy_len", 64'(n), 64'(DEPTH - 1));
    for (int a = 0; a < DEPTH; a++) begin
      idle_in(); set_raddr(0, a); set_raddr(1, a); tap_addr = AW'(a); #1;
      check_eq($sformatf("clr_data%0d", a), 64'(rdata[DW-1:0]), 64'(0));
      check_eq($sformatf("clr_pend%0d", a), 64'(rpend), 64'(0));
      cycle();
    end

    // Reset in the middle of a clear walk (counter at 10).
    idle_in(); we0 = 1; waddr0 = 20; wdata0 = 32'h2020; cycle();
    idle_in(); clr = 1; cycle();
    idle_in(); set_raddr(0, 20); tap_addr = 20;
    repeat (9) cycle();
    check_eq("pre_rst_busy", 64'(busy), 64'(1));
    check_eq("pre_rst_data", 64'(rdata[DW-1:0]), 64'h2020);
    #2; rst = 1; #1;
    check_eq("mid_rst_busy", 64'(busy), 64'(0));
    check_eq("mid_rst_rdata", 64'(rdata), 64'(0));
    check_eq("mid_rst_tap", 64'(tap_data), 64'(0));
    check_eq("mid_rst_rpend", 64'(rpend), 64'(0));
    cycle();
    rst = 0; idle_in(); we0 = 1; waddr0 = 12; wdata0 = 32'hCAFE; cycle();
    idle_in(); set_raddr(0, 12); #1;
    check_eq("post_rst_wr", 64'(rdata[DW-1:0]), 64'hCAFE);
    check_eq("post_rst_busy", 64'(busy), 64'(0));
    cycle();

    // Random traffic with occasional clears and resets.
    repeat (600) begin
      rand_in();
      clr = ($urandom_range(0, 39) == 0);
      rst = ($urandom_range(0, 199) == 0);
      cycle();
    end
    rst = 0; idle_in();
    cycle();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
